// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter between the CPU core and a DMA/loader requester.
// One access at a time runs IDLE -> ACC (wait states / timeout) -> RESP.
module mem_bus_arbiter #(
   parameter int STARVE_LIMIT = 8,
   parameter int TIMEOUT      = 15
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [15:0] i_cpu_addr,
   input  logic [15:0] i_cpu_wdata,
   output logic        o_cpu_ack,
   output logic        o_cpu_err,
   output logic [15:0] o_cpu_rdata,
   output logic        o_cpu_stall,
   input  logic        i_dma_req,
   input  logic        i_dma_we,
   input  logic [15:0] i_dma_addr,
   input  logic [15:0] i_dma_wdata,
   output logic        o_dma_ack,
   output logic        o_dma_err,
   output logic [15:0] o_dma_rdata,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_mem_wdata,
   output logic        o_mem_re,
   output logic        o_mem_we,
   input  logic        i_mem_ready,
   input  logic [15:0] i_mem_rdata,
   output logic [1:0]  o_owner
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC  = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [1:0]  r_owner;
   logic        r_we;
   logic        r_err;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_cpu_rdata;
   logic [15:0] r_dma_rdata;
   logic [7:0]  r_to_cnt;
   logic [7:0]  r_starve_cnt;
   logic        w_grant_cpu;
   logic        w_grant_dma;
   logic        w_ready_hit;
   logic        w_timeout_hit;
   logic        w_starve;
   logic        w_in_acc;
   logic        w_in_resp;
   logic        w_cpu_ack;
   logic        w_dma_ack;

   assign w_starve = (r_starve_cnt == STARVE_MAX);

   // Next-state and arbitration decision
   always_comb begin
      w_next_state  = r_state;
      w_grant_cpu   = 1'b0;
      w_grant_dma   = 1'b0;
      w_ready_hit   = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cpu_req | i_dma_req) begin
               w_next_state = ST_ACC;
               if (i_dma_req & (~i_cpu_req | w_starve)) begin
                  w_grant_dma = 1'b1;
               end else begin
                  w_grant_cpu = 1'b1;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (i_mem_ready) begin
               w_ready_hit  = 1'b1;
               w_next_state = ST_RESP;
            end else if (r_to_cnt == TO_LAST) begin
               w_timeout_hit = 1'b1;
               w_next_state  = ST_RESP;
            end else begin
               w_next_state = ST_ACC;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Access latches, owner, timeout counter and error flag
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner  <= OWN_NONE;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= 16'h0000;
         r_wdata  <= 16'h0000;
         r_to_cnt <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_dma) begin
                  r_owner  <= OWN_DMA;
                  r_we     <= i_dma_we;
                  r_addr   <= i_dma_addr;
                  r_wdata  <= i_dma_wdata;
                  r_to_cnt <= 8'd0;
               end else if (w_grant_cpu) begin
                  r_owner  <= OWN_CPU;
                  r_we     <= i_cpu_we;
                  r_addr   <= i_cpu_addr;
                  r_wdata  <= i_cpu_wdata;
                  r_to_cnt <= 8'd0;
               end
            end
            ST_ACC: begin
               if (w_ready_hit) begin
                  r_err <= 1'b0;
               end else if (w_timeout_hit) begin
                  r_err <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + 8'd1;
               end
            end
            ST_RESP: r_owner <= OWN_NONE;
            default: r_owner <= OWN_NONE;
         endcase
      end
   end

   // Per-requester read data; a timed-out read returns zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cpu_rdata <= 16'h0000;
         r_dma_rdata <= 16'h0000;
      end else if ((w_ready_hit | w_timeout_hit) & ~r_we) begin
         if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= w_ready_hit ? i_mem_rdata : 16'h0000;
         end else if (r_owner == OWN_DMA) begin
            r_dma_rdata <= w_ready_hit ? i_mem_rdata : 16'h0000;
         end
      end
   end

   // DMA starvation counter: counts pending cycles while another party holds the bus
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_starve_cnt <= 8'd0;
      end else if (~i_dma_req | w_grant_dma) begin
         r_starve_cnt <= 8'd0;
      end else if ((r_owner != OWN_DMA) & ~w_starve) begin
         r_starve_cnt <= r_starve_cnt + 8'd1;
      end
   end

   assign w_in_acc  = (r_state == ST_ACC);
   assign w_in_resp = (r_state == ST_RESP);
   assign w_cpu_ack = w_in_resp & (r_owner == OWN_CPU);
   assign w_dma_ack = w_in_resp & (r_owner == OWN_DMA);

   assign o_mem_re    = w_in_acc & ~r_we;
   assign o_mem_we    = w_in_acc & r_we;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_owner     = r_owner;
   assign o_cpu_ack   = w_cpu_ack;
   assign o_cpu_err   = w_cpu_ack & r_err;
   assign o_cpu_rdata = r_cpu_rdata;
   assign o_cpu_stall = i_cpu_req & ~w_cpu_ack;
   assign o_dma_ack   = w_dma_ack;
   assign o_dma_err   = w_dma_ack & r_err;
   assign o_dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed transaction table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
   localparam int STARVE_LIMIT = 8;
   localparam int TIMEOUT      = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
   logic        cpu_ack, cpu_err, cpu_stall, dma_ack, dma_err, mem_re, mem_we;
   logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
   logic [1:0]  owner;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
      .o_cpu_ack(cpu_ack), .o_cpu_err(cpu_err), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
      .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
      .o_dma_ack(dma_ack), .o_dma_err(dma_err), .o_dma_rdata(dma_rdata),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_re(mem_re), .o_mem_we(mem_we),
      .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .o_owner(owner)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed transaction table: ready_at = ACC cycle index of ready (0 = never)
   typedef struct {
      logic        dma;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      int          ready_at;
      logic [15:0] mem_data;
      int          exp_ack;
      int          exp_strobes;
      logic        exp_err;
      logic [15:0] exp_cpu_rdata;
      logic [15:0] exp_dma_rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic run_vec(input vec_t v);
      int   strobes = 0;
      int   ack_at  = 0;
      logic ack;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = v.mem_data;
      if (v.dma) begin
         dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      #1;
      if (!v.dma) chk("stall_at_request", cpu_stall, 1'b1);
      for (int k = 1; k <= 40 && ack_at == 0; k++) begin
         @(negedge clk);
         mem_ready = (k == v.ready_at);
         #1;
         if (mem_re | mem_we) strobes++;
         if (k == 1) begin
            chk("owner_in_acc", owner, v.dma ? 2'b10 : 2'b01);
            chk("mem_addr", mem_addr, v.addr);
            chk("strobe_dir", {mem_re, mem_we}, v.we ? 2'b01 : 2'b10);
            if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
            if (!v.dma) chk("stall_in_acc", cpu_stall, 1'b1);
         end
         ack = v.dma ? dma_ack : cpu_ack;
         if (ack) begin
            ack_at = k;
            chk("err", v.dma ? dma_err : cpu_err, v.exp_err);
            chk("cpu_rdata", cpu_rdata, v.exp_cpu_rdata);
            chk("dma_rdata", dma_rdata, v.exp_dma_rdata);
            if (!v.dma) chk("stall_at_ack", cpu_stall, 1'b0);
         end
      end
      chk("ack_cycle", ack_at, v.exp_ack);
      chk("strobe_cycles", strobes, v.exp_strobes);
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
      #1;
      chk("owner_after_ack", owner, 2'b00);
   endtask

   // Reference model: one access at a time, tracked as "running" then "reporting"
   int          m_owner, m_pend, m_waited;
   bit          m_running, m_reporting, m_we, m_err;
   logic [15:0] m_addr, m_wdata;
   logic [15:0] m_rdata[2];

   task automatic model_reset();
      m_owner = 0; m_pend = 0; m_waited = 0;
      m_running = 0; m_reporting = 0; m_we = 0; m_err = 0;
      m_addr = 16'h0000; m_wdata = 16'h0000;
      m_rdata[0] = 16'h0000; m_rdata[1] = 16'h0000;
   endtask

   task automatic model_step();
      int prev_owner = m_owner;
      int winner     = 0;
      if (m_reporting) begin
         m_reporting = 0;
         m_owner     = 0;
      end else if (m_running) begin
         m_waited++;
         if (mem_ready) begin
            if (!m_we) m_rdata[m_owner-1] = mem_rdata;
            m_err = 0; m_running = 0; m_reporting = 1;
         end else if (m_waited == TIMEOUT) begin
            if (!m_we) m_rdata[m_owner-1] = 16'h0000;
            m_err = 1; m_running = 0; m_reporting = 1;
         end
      end else if (cpu_req || dma_req) begin
         winner    = (dma_req && (!cpu_req || m_pend >= STARVE_LIMIT)) ? 2 : 1;
         m_owner   = winner;
         m_we      = (winner == 2) ? dma_we : cpu_we;
         m_addr    = (winner == 2) ? dma_addr : cpu_addr;
         m_wdata   = (winner == 2) ? dma_wdata : cpu_wdata;
         m_running = 1;
         m_waited  = 0;
      end
      if (!dma_req || winner == 2) m_pend = 0;
      else if (prev_owner != 2 && m_pend < STARVE_LIMIT) m_pend++;
   endtask

   initial begin
      int owners[$];
      int exp_owners[5] = '{1, 1, 1, 2, 1};
      bit drop_dma;
      bit cpu_acked, dma_acked;
      bit e_cpu_ack, e_dma_ack;
      int ack_at;

      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
      mem_ready = 1'b0; mem_rdata = 16'h0000;

      vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000,  1, 16'hBEEF,  2,  1, 1'b0, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 16'h0040, 16'h5A5A,  4, 16'hFFFF,  5,  4, 1'b0, 16'hBEEF, 16'h0000};
      vecs[2] = '{1'b0, 1'b0, 16'h0100, 16'h0000,  0, 16'h1111, 16, 15, 1'b1, 16'h0000, 16'h0000};
      vecs[3] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 15, 16'h1357, 16, 15, 1'b0, 16'h1357, 16'h0000};
      vecs[4] = '{1'b1, 1'b0, 16'h0300, 16'h0000,  2, 16'hCAFE,  3,  2, 1'b0, 16'h1357, 16'hCAFE};
      vecs[5] = '{1'b1, 1'b1, 16'h0400, 16'hA5A5,  0, 16'h2222, 16, 15, 1'b1, 16'h1357, 16'hCAFE};
      vecs[6] = '{1'b0, 1'b1, 16'h0500, 16'h0F0F,  3, 16'h3333,  4,  3, 1'b0, 16'h1357, 16'hCAFE};

      // Reset values; stall follows the request even in reset
      #12;
      chk("reset_outputs", {owner, mem_re, mem_we, cpu_ack, cpu_err, dma_ack, dma_err}, 8'h00);
      chk("reset_rdata", {cpu_rdata, dma_rdata}, 32'h0);
      chk("reset_mem_bus", {mem_addr, mem_wdata}, 32'h0);
      cpu_req = 1'b1; #1;
      chk("reset_stall_hi", cpu_stall, 1'b1);
      cpu_req = 1'b0; #1;
      chk("reset_stall_lo", cpu_stall, 1'b0);
      @(negedge clk); rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Starvation: CPU requests continuously, DMA pending
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
      mem_ready = 1'b1; mem_rdata = 16'h7777;
      drop_dma = 0;
      for (int c = 0; c < 60 && owners.size() < 5; c++) begin
         @(negedge clk);
         if (drop_dma) begin dma_req = 1'b0; drop_dma = 0; end
         #1;
         if (cpu_ack && dma_ack) chk("double_ack", 1'b1, 1'b0);
         if (cpu_ack) owners.push_back(1);
         if (dma_ack) begin owners.push_back(2); drop_dma = 1; end
      end
      chk("starve_ack_count", owners.size(), 5);
      foreach (owners[i]) if (i < 5) chk($sformatf("starve_grant%0d", i), owners[i], exp_owners[i]);
      @(negedge clk);
      cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
      repeat (3) @(negedge clk);

      // Reset asserted mid-ACC, then a pending CPU read completes normally
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777; mem_rdata = 16'h4321;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_reset_re", mem_re, 1'b1);
      #2; rst_n = 1'b0; #1;
      chk("midreset_outputs", {owner, mem_re, mem_we, cpu_ack, dma_ack}, 6'h00);
      chk("midreset_rdata", {cpu_rdata, dma_rdata}, 32'h0);
      @(negedge clk); #1;
      chk("midreset_no_ack", {cpu_ack, dma_ack}, 2'b00);
      rst_n = 1'b1; mem_ready = 1'b1;
      ack_at = 0;
      for (int k = 1; k <= 10 && ack_at == 0; k++) begin
         @(negedge clk); #1;
         if (cpu_ack) begin
            ack_at = k;
            chk("post_reset_rdata", cpu_rdata, 16'h4321);
            chk("post_reset_err", cpu_err, 1'b0);
         end
      end
      chk("post_reset_ack_cycle", ack_at, 2);
      @(negedge clk);
      cpu_req = 1'b0; mem_ready = 1'b0;

      // Random traffic against the reference model
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cpu_acked = 0; dma_acked = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cpu_req && (cpu_acked || $urandom_range(0, 59) == 0)) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
         end
         if (dma_req && (dma_acked || $urandom_range(0, 59) == 0)) dma_req = 1'b0;
         else if (!dma_req && $urandom_range(0, 3) == 0) begin
            dma_req = 1'b1; dma_we = 1'($urandom_range(0, 1));
            dma_addr = 16'($urandom); dma_wdata = 16'($urandom);
         end
         mem_ready = ($urandom_range(0, 3) == 0);
         mem_rdata = 16'($urandom);
         #1;
         e_cpu_ack = m_reporting && m_owner == 1;
         e_dma_ack = m_reporting && m_owner == 2;
         chk("rnd_ctrl",
             {owner, mem_re, mem_we, cpu_ack, cpu_err, dma_ack, dma_err, cpu_stall},
             {2'(m_owner), m_running && !m_we, m_running && m_we,
              e_cpu_ack, e_cpu_ack && m_err, e_dma_ack, e_dma_ack && m_err,
              cpu_req && !e_cpu_ack});
         chk("rnd_bus", {mem_addr, mem_wdata}, {m_addr, m_wdata});
         chk("rnd_rdata", {cpu_rdata, dma_rdata}, {m_rdata[0], m_rdata[1]});
         cpu_acked = e_cpu_ack;
         dma_acked = e_dma_ack;
         @(posedge clk);
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
